// File: rtl/fifo_rd_stream.sv
`default_nettype none
// ============================================================================
// Module      : fifo_rd_stream
// Description : Reads a synchronous FIFO (1-cycle read latency) and presents
//               the words as a valid/ready stream, with a delivered-beat count.
// Revision    : 1.0 - initial release
// ============================================================================
module fifo_rd_stream #(
    parameter int DATAW = 8,
    parameter int CNTW  = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             i_rd_empty,
    output logic             o_rd_en,
    input  logic [DATAW-1:0] i_rd_data,
    output logic             o_valid,
    input  logic             i_ready,
    output logic [DATAW-1:0] o_data,
    output logic [CNTW-1:0]  o_beats
);

    logic             r_out_vld;
    logic [DATAW-1:0] r_out_data;
    logic             r_skid_vld;
    logic [DATAW-1:0] r_skid_data;
    logic             r_infl;
    logic [CNTW-1:0]  r_beats;

    logic             w_pop;
    logic [1:0]       w_occ;
    logic [1:0]       w_occ_after;

    assign w_pop       = r_out_vld & i_ready;
    assign w_occ       = {1'b0, r_out_vld} + {1'b0, r_skid_vld} + {1'b0, r_infl};
    assign w_occ_after = w_occ - {1'b0, w_pop};

    // A new read is only issued when its word is guaranteed a slot on arrival.
    assign o_rd_en = rst_n & ~i_rd_empty & (w_occ_after < 2'd2);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_out_vld   <= 1'b0;
            r_out_data  <= '0;
            r_skid_vld  <= 1'b0;
            r_skid_data <= '0;
            r_infl      <= 1'b0;
            r_beats     <= '0;
        end else begin
            r_infl <= o_rd_en;
            if (w_pop) begin
                r_beats <= r_beats + CNTW'(1);
            end
            if (r_infl) begin
                if (!r_skid_vld && (!r_out_vld || w_pop)) begin
                    r_out_vld  <= 1'b1;
                    r_out_data <= i_rd_data;
                end else if (r_skid_vld && w_pop) begin
                    r_out_data  <= r_skid_data;
                    r_skid_data <= i_rd_data;
                end else begin
                    r_skid_vld  <= 1'b1;
                    r_skid_data <= i_rd_data;
                end
            end else if (w_pop) begin
                if (r_skid_vld) begin
                    r_out_data <= r_skid_data;
                    r_skid_vld <= 1'b0;
                end else begin
                    r_out_vld <= 1'b0;
                end
            end
        end
    end

    assign o_valid = r_out_vld;
    assign o_data  = r_out_data;
    assign o_beats = r_beats;

`ifndef SYNTHESIS
    a_occ_max : assert property (@(posedge clk) disable iff (!rst_n) (w_occ <= 2'd2));
`endif

endmodule
`default_nettype wire

// File: tb/tb_fifo_rd_stream.sv
`default_nettype none
// ============================================================================
// Module      : tb_fifo_rd_stream
// Description : Self-checking bench: FIFO model, push-order scoreboard and
//               per-cycle stream-protocol checks for fifo_rd_stream.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_fifo_rd_stream;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    // main instance (CNTW=16) and its FIFO model
    logic        rd_empty, rd_en, valid, ready;
    logic [7:0]  rd_data = '0;
    logic [7:0]  data;
    logic [15:0] beats;

    logic [7:0]  mem [0:1023];
    int          wr_ptr = 0;
    int          rd_ptr = 0;
    assign rd_empty = (rd_ptr == wr_ptr);

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) rd_ptr <= wr_ptr;
        else if (rd_en && (rd_ptr != wr_ptr)) begin
            rd_data <= mem[10'(rd_ptr)];
            rd_ptr  <= rd_ptr + 1;
        end
    end

    fifo_rd_stream #(.DATAW(8), .CNTW(16)) u_dut (
        .clk(clk), .rst_n(rst_n), .i_rd_empty(rd_empty), .o_rd_en(rd_en),
        .i_rd_data(rd_data), .o_valid(valid), .i_ready(ready),
        .o_data(data), .o_beats(beats)
    );

    // narrow-counter instance fed by an endless counting source
    logic        empty4, rd_en4, valid4;
    logic        ready4 = 1'b1;
    logic [7:0]  rd_data4 = '0;
    logic [7:0]  data4;
    logic [3:0]  beats4;
    int          total4 = 0;
    int          issued4 = 0;
    assign empty4 = (issued4 == total4);

    always @(posedge clk) begin
        if (rd_en4 && !empty4) begin
            rd_data4 <= 8'(issued4 + 1);
            issued4  <= issued4 + 1;
        end
    end

    fifo_rd_stream #(.DATAW(8), .CNTW(4)) u_dut4 (
        .clk(clk), .rst_n(rst_n), .i_rd_empty(empty4), .o_rd_en(rd_en4),
        .i_rd_data(rd_data4), .o_valid(valid4), .i_ready(ready4),
        .o_data(data4), .o_beats(beats4)
    );

    int nchk = 0;
    int nerr = 0;

    task automatic check(input string nm, input int act, input int exp);
        nchk++;
        if (act != exp) begin
            nerr++;
            $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h) at t=%0t",
                     nm, act, act, exp, exp, $time);
        end
    endtask

    // reference model state: expected words are simply the push order
    int         cyc = 0;
    int         exp_ptr = 0;
    int         mbeats = 0;
    int         outst = 0;
    logic       prev_valid = 1'b0, prev_ready = 1'b0;
    logic [7:0] prev_data = '0;
    int         n_rd, n_pop, first_rd, last_rd, first_pop, last_pop;
    logic [7:0] got [0:255];
    int         mb4 = 0, exp4 = 1, n4_pop = 0;
    logic       wrap4 = 1'b0;
    logic [3:0] prev_b4 = '0;

    always @(negedge clk) begin
        cyc++;
        if (!rst_n) begin
            check("reset_valid", int'(valid), 0);
            check("reset_beats", int'(beats), 0);
            check("reset_rd_en", int'(rd_en), 0);
            check("reset_beats4", int'(beats4), 0);
            exp_ptr    = wr_ptr;
            mbeats     = 0;
            outst      = 0;
            prev_valid = 1'b0;
            mb4        = 0;
            exp4       = issued4 + 1;
            prev_b4    = '0;
        end else begin
            check("rd_while_empty", int'(rd_en && rd_empty), 0);
            check("words_held_le2", int'(outst <= 2), 1);
            check("beats", int'(beats), mbeats % 65536);
            if (prev_valid && !prev_ready) begin
                check("hold_valid", int'(valid), 1);
                check("hold_data", int'(data), int'(prev_data));
            end
            if (valid && ready) begin
                if (exp_ptr == wr_ptr) check("extra_beat", int'(data), -1);
                else check("order", int'(data), int'(mem[10'(exp_ptr)]));
                exp_ptr++;
                if (n_pop < 256) got[n_pop] = data;
                if (first_pop < 0) first_pop = cyc;
                last_pop = cyc;
                n_pop++;
                mbeats++;
            end
            if (rd_en) begin
                if (first_rd < 0) first_rd = cyc;
                last_rd = cyc;
                n_rd++;
            end
            outst += int'(rd_en) - int'(valid && ready);
            prev_valid = valid;
            prev_ready = ready;
            prev_data  = data;

            check("rd4_while_empty", int'(rd_en4 && empty4), 0);
            check("beats4", int'(beats4), mb4 % 16);
            if (prev_b4 == 4'd15 && beats4 == 4'd0) wrap4 = 1'b1;
            prev_b4 = beats4;
            if (valid4 && ready4) begin
                check("order4", int'(data4), exp4 % 256);
                exp4++;
                mb4++;
                n4_pop++;
            end
        end
    end

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [7:0] d);
        mem[10'(wr_ptr)] = d;
        wr_ptr++;
    endtask

    task automatic clr_stats();
        n_rd = 0; n_pop = 0;
        first_rd = -1; last_rd = -1; first_pop = -1; last_pop = -1;
    endtask

    initial begin
        #100000;
        $display("FAIL timeout: bench did not finish within bound");
        $fatal(1);
    end

    initial begin
        int pushed;
        clr_stats();
        ready = 1'b1;
        step(3);
        rst_n = 1'b1;
        step(1);

        // four words, consumer always ready
        clr_stats();
        push(8'h11); push(8'h22); push(8'h33); push(8'h44);
        step(8);
        check("t1_reads", n_rd, 4);
        check("t1_read_span", last_rd - first_rd, 3);
        check("t1_pops", n_pop, 4);
        check("t1_pop_span", last_pop - first_pop, 3);
        check("t1_latency", first_pop - first_rd, 2);
        check("t1_first", int'(got[0]), 'h11);
        check("t1_last", int'(got[3]), 'h44);
        check("t1_beats", int'(beats), 4);
        check("t1_idle", int'(valid), 0);

        // stalled consumer: only two reads may be issued
        ready = 1'b0;
        clr_stats();
        push(8'h11); push(8'h22); push(8'h33); push(8'h44);
        step(10);
        check("t2_stall_reads", n_rd, 2);
        check("t2_stall_valid", int'(valid), 1);
        check("t2_stall_data", int'(data), 'h11);
        check("t2_stall_pops", n_pop, 0);
        ready = 1'b1;
        step(6);
        check("t2_pops", n_pop, 4);
        check("t2_no_gap", last_pop - first_pop, 3);
        check("t2_second", int'(got[1]), 'h22);
        check("t2_last", int'(got[3]), 'h44);
        check("t2_reads", n_rd, 4);
        check("t2_beats", int'(beats), 8);

        // random push rate and random backpressure
        clr_stats();
        pushed = 0;
        for (int c = 0; c < 5000 && !(pushed == 200 && exp_ptr == wr_ptr); c++) begin
            ready = 1'($urandom_range(0, 1));
            if (pushed < 200 && $urandom_range(0, 2) != 0) begin
                push(8'($urandom));
                pushed++;
            end
            step(1);
        end
        ready = 1'b1;
        step(3);
        check("t3_drained", int'(exp_ptr == wr_ptr), 1);
        check("t3_pops", n_pop, 200);
        check("t3_beats", int'(beats), 208);

        // single word into an empty FIFO
        clr_stats();
        push(8'hA5);
        step(5);
        check("t4_reads", n_rd, 1);
        check("t4_pops", n_pop, 1);
        check("t4_latency", first_pop - first_rd, 2);
        check("t4_data", int'(got[0]), 'hA5);
        check("t4_idle", int'(valid), 0);
        check("t4_beats", int'(beats), 209);

        // reset while words are buffered and a read is in flight
        ready = 1'b0;
        for (int i = 0; i < 5; i++) push(8'(8'hD0 + i));
        step(2);
        check("t5_loaded", int'(valid), 1);
        #3;
        rst_n = 1'b0;
        #1;
        check("t5_rst_valid", int'(valid), 0);
        check("t5_rst_beats", int'(beats), 0);
        check("t5_rst_rd_en", int'(rd_en), 0);
        step(2);
        rst_n = 1'b1;
        ready = 1'b1;
        step(1);
        clr_stats();
        push(8'hC1); push(8'hC2);
        step(6);
        check("t5_pops", n_pop, 2);
        check("t5_fresh0", int'(got[0]), 'hC1);
        check("t5_fresh1", int'(got[1]), 'hC2);
        check("t5_beats", int'(beats), 2);

        // 4-bit beat counter wraps
        total4 = 17;
        step(25);
        check("t6_pops4", n4_pop, 17);
        check("t6_wrapped", int'(wrap4), 1);
        check("t6_beats4", int'(beats4), 1);

        $display("Result: errors=%0d of %0d checks", nerr, nchk);
        $finish;
    end

endmodule
`default_nettype wire
